// File: rtl/apb_master.sv
// APB requester: local req/write/addr/wdata -> SETUP/ACCESS transfer to two slaves selected by addr[7].
// Optional ACCESS timeout abort compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       transfer_req,
    input  logic       transfer_wr,
    input  logic [7:0] transfer_addr,
    input  logic [7:0] transfer_wdata,
    output logic       transfer_ready,
    output logic [7:0] rdata_out,
    output logic       done,
    output logic       err,
    output logic       PSEL1,
    output logic       PSEL2,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA1,
    input  logic [7:0] PRDATA2,
    input  logic       PREADY
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t     r_state, w_next;
    logic       w_accept, w_complete, w_abort;
    logic [7:0] w_addr_nxt;
    logic       r_wr, r_psel1, r_psel2, r_penable, r_done, r_err;
    logic [7:0] r_addr, r_wdata, r_rdata;

    assign transfer_ready = (r_state == IDLE) | ((r_state == ACCESS) & PREADY);
    assign w_accept       = transfer_ready & transfer_req;
    assign w_complete     = (r_state == ACCESS) & PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    logic [7:0] r_cnt;

    // Abort on the edge that would bring the wait count up to TIMEOUT_CYCLES.
    assign w_abort = (r_state == ACCESS) & ~PREADY & (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_cnt <= 8'h00;
        else if (r_state != ACCESS)
            r_cnt <= 8'h00;
        else if (!PREADY)
            r_cnt <= r_cnt + 8'h01;
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_abort      = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = SETUP;
            SETUP:   w_next = ACCESS;
            ACCESS: begin
                if (w_abort)
                    w_next = IDLE;
                else if (PREADY)
                    w_next = w_accept ? SETUP : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Slave select must follow the command that will be on the bus next cycle.
    assign w_addr_nxt = w_accept ? transfer_addr : r_addr;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr      <= 1'b0;
            r_addr    <= 8'h00;
            r_wdata   <= 8'h00;
            r_psel1   <= 1'b0;
            r_psel2   <= 1'b0;
            r_penable <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_wr    <= transfer_wr;
                r_addr  <= transfer_addr;
                r_wdata <= transfer_wdata;
            end
            r_psel1   <= (w_next != IDLE) & ~w_addr_nxt[7];
            r_psel2   <= (w_next != IDLE) &  w_addr_nxt[7];
            r_penable <= (w_next == ACCESS);
            r_done    <= w_complete | w_abort;
            r_err     <= w_abort;
            if (w_complete && !r_wr)
                r_rdata <= r_addr[7] ? PRDATA2 : PRDATA1;
        end
    end

    assign PSEL1     = r_psel1;
    assign PSEL2     = r_psel2;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_wr;
    assign PADDR     = r_addr;
    assign PWDATA    = r_wdata;
    assign rdata_out = r_rdata;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: stimulus pushes expected completions, a negedge monitor checks them on done.
module tb_apb_master;
    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       transfer_req, transfer_wr;
    logic [7:0] transfer_addr, transfer_wdata;
    logic       transfer_ready;
    logic [7:0] rdata_out;
    logic       done, err;
    logic       PSEL1, PSEL2, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
    logic       PREADY;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rdata = 8'h00;

    apb_master #(.TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .transfer_req(transfer_req), .transfer_wr(transfer_wr),
        .transfer_addr(transfer_addr), .transfer_wdata(transfer_wdata),
        .transfer_ready(transfer_ready), .rdata_out(rdata_out),
        .done(done), .err(err),
        .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] rd, input logic e);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        sb_q.push_back(x);
    endtask

    task automatic req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        transfer_req   = 1'b1;
        transfer_wr    = wr;
        transfer_addr  = addr;
        transfer_wdata = wdata;
    endtask

    always @(negedge PCLK) begin
        if (PSEL1 && PSEL2) begin
            errors++;
            $display("FAIL psel_onehot: got PSEL1=1 PSEL2=1 expected at most one at %0t", $time);
        end
        if (done) begin
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_rdata", rdata_out, e.rdata);
                chk("done_err", err, e.err);
            end
        end
    end

    task automatic write_scenario(input string tag);
        PREADY = 1'b1;
        req(1'b1, 8'h05, 8'h12);
        push_exp(exp_rdata, 1'b0);
        tick();
        transfer_req = 1'b0;
        chk({tag, "_setup_psel1"}, PSEL1, 1);
        chk({tag, "_setup_psel2"}, PSEL2, 0);
        chk({tag, "_setup_penable"}, PENABLE, 0);
        chk({tag, "_setup_paddr"}, PADDR, 8'h05);
        chk({tag, "_setup_pwdata"}, PWDATA, 8'h12);
        chk({tag, "_setup_pwrite"}, PWRITE, 1);
        tick();
        chk({tag, "_access_penable"}, PENABLE, 1);
        chk({tag, "_access_done"}, done, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_idle_psel1"}, PSEL1, 0);
        chk({tag, "_idle_penable"}, PENABLE, 0);
    endtask

    initial begin
        PRESETn = 1'b0;
        transfer_req = 1'b0; transfer_wr = 1'b0;
        transfer_addr = 8'h00; transfer_wdata = 8'h00;
        PRDATA1 = 8'h00; PRDATA2 = 8'h00; PREADY = 1'b0;
        #12;
        chk("rst_psel1", PSEL1, 0);
        chk("rst_psel2", PSEL2, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_paddr", PADDR, 8'h00);
        chk("rst_rdata", rdata_out, 8'h00);
        PRESETn = 1'b1;
        #1;
        chk("rst_ready", transfer_ready, 1);
        tick();

        write_scenario("wr");

        // Read-back from slave1
        PRDATA1 = 8'h12; PRDATA2 = 8'h00;
        req(1'b0, 8'h05, 8'h99);
        push_exp(8'h12, 1'b0);
        exp_rdata = 8'h12;
        tick();
        transfer_req = 1'b0;
        chk("rd_setup_pwrite", PWRITE, 0);
        chk("rd_setup_psel1", PSEL1, 1);
        chk("rd_setup_pwdata", PWDATA, 8'h99);
        tick();
        chk("rd_access_pwrite", PWRITE, 0);
        chk("rd_access_penable", PENABLE, 1);
        tick();
        chk("rd_done", done, 1);
        chk("rd_rdata", rdata_out, 8'h12);

        // Slave2 decode
        PRDATA1 = 8'h3C; PRDATA2 = 8'hA5;
        req(1'b0, 8'h83, 8'h00);
        push_exp(8'hA5, 1'b0);
        exp_rdata = 8'hA5;
        tick();
        transfer_req = 1'b0;
        chk("s2_psel2", PSEL2, 1);
        chk("s2_psel1", PSEL1, 0);
        chk("s2_paddr", PADDR, 8'h83);
        tick();
        tick();
        chk("s2_done", done, 1);
        chk("s2_rdata", rdata_out, 8'hA5);

        // Back-to-back with 3 wait states on the first transfer
        PREADY = 1'b0;
        req(1'b1, 8'h10, 8'h77);
        push_exp(exp_rdata, 1'b0);
        tick();
        req(1'b0, 8'h90, 8'h00);
        PRDATA2 = 8'h5A;
        push_exp(8'h5A, 1'b0);
        chk("b2b_setup_psel1", PSEL1, 1);
        chk("b2b_setup_paddr", PADDR, 8'h10);
        tick();
        chk("b2b_access_penable", PENABLE, 1);
        chk("b2b_wait_ready", transfer_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("b2b_wait_penable", PENABLE, 1);
            chk("b2b_wait_done", done, 0);
            chk("b2b_wait_pwdata", PWDATA, 8'h77);
        end
        PREADY = 1'b1;
        #1;
        chk("b2b_complete_ready", transfer_ready, 1);
        tick();
        transfer_req = 1'b0;
        chk("b2b_done1", done, 1);
        chk("b2b_setup2_psel2", PSEL2, 1);
        chk("b2b_setup2_psel1", PSEL1, 0);
        chk("b2b_setup2_penable", PENABLE, 0);
        chk("b2b_setup2_paddr", PADDR, 8'h90);
        tick();
        chk("b2b_access2_penable", PENABLE, 1);
        tick();
        chk("b2b_done2", done, 1);
        chk("b2b_rdata2", rdata_out, 8'h5A);
        exp_rdata = 8'h5A;

`ifdef APB_MASTER_TIMEOUT_EN
        PREADY = 1'b0;
        req(1'b1, 8'h20, 8'h33);
        push_exp(exp_rdata, 1'b1);
        tick();
        transfer_req = 1'b0;
        chk("to_setup_psel1", PSEL1, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_wait_penable", PENABLE, 1);
            chk("to_wait_done", done, 0);
        end
        req(1'b1, 8'h40, 8'h00);
        tick();
        transfer_req = 1'b0;
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_psel1", PSEL1, 0);
        chk("to_psel2", PSEL2, 0);
        chk("to_penable", PENABLE, 0);
        chk("to_rdata", rdata_out, exp_rdata);
        tick();
        chk("to_err_pulse", err, 0);
        chk("to_done_pulse", done, 0);
`else
        PREADY = 1'b0;
        req(1'b1, 8'h20, 8'h33);
        push_exp(exp_rdata, 1'b0);
        tick();
        transfer_req = 1'b0;
        tick();
        repeat (100) tick();
        chk("nto_still_psel1", PSEL1, 1);
        chk("nto_still_penable", PENABLE, 1);
        chk("nto_err", err, 0);
        PREADY = 1'b1;
        tick();
        chk("nto_done", done, 1);
        chk("nto_err_done", err, 0);
`endif
        tick();

        // Asynchronous reset in the middle of ACCESS
        PREADY = 1'b0;
        req(1'b1, 8'h84, 8'h55);
        tick();
        transfer_req = 1'b0;
        tick();
        chk("mr_access_psel2", PSEL2, 1);
        chk("mr_access_penable", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1;
        chk("mr_psel1", PSEL1, 0);
        chk("mr_psel2", PSEL2, 0);
        chk("mr_penable", PENABLE, 0);
        chk("mr_pwrite", PWRITE, 0);
        chk("mr_paddr", PADDR, 8'h00);
        chk("mr_pwdata", PWDATA, 8'h00);
        chk("mr_rdata", rdata_out, 8'h00);
        chk("mr_done", done, 0);
        chk("mr_err", err, 0);
        exp_rdata = 8'h00;
        PREADY = 1'b1;
        #10 PRESETn = 1'b1;
        tick();
        chk("mr_post_done", done, 0);
        chk("mr_post_psel2", PSEL2, 0);
        tick();

        write_scenario("wr2");
        tick();
        tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
